// File: rtl/i2c_pkg.sv
// Shared types for the oversampled I2C write-receiver.
// I2C_RX_STRETCH_EN adds the STRETCH state.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
`ifdef I2C_RX_STRETCH_EN
        ST_STRETCH,
`endif
        ST_IGNORE
    } i2c_rx_state_t;

endpackage

// File: rtl/i2c_rx_fifo.sv
// Synchronous FIFO holding {first,data} entries for the I2C receiver.
// Simultaneous push and pop on a full FIFO is accepted.
module i2c_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] count;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != LW'(DEPTH)) || do_pop);
    assign rdata   = mem[rptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_target_rx.sv
// Oversampled I2C target write-receiver with address match and receive FIFO.
// Define I2C_RX_STRETCH_EN to hold SCL low on a full FIFO instead of NACKing.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH_US  = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scl_i,
    input  logic                          sda_i,
    output logic                          scl_oe,
    output logic                          sda_oe,
    input  logic [I2C_ADDR_W-1:0]         own_addr,
    output logic [I2C_BYTE_W-1:0]         m_data,
    output logic                          m_first,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          bus_busy,
    output logic                          stop_o,
    output logic                          overflow
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || SYNC_STAGES < 2 || CLK_FREQ < 1 || STRETCH_US < 0) begin : g_bad_param
        $error("i2c_target_rx: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    i2c_rx_state_t          state;
    logic [2:0]             bit_cnt;
    logic                   got8;
    logic [I2C_BYTE_W-1:0]  shreg;
    logic                   matched;
    logic                   first_pend;

    logic                   pop;
    logic                   full;
    logic                   room;
    logic                   push;
    logic                   push_data;
    logic [I2C_BYTE_W:0]    head;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    assign pop       = m_valid & m_ready;
    assign full      = (level == LW'(FIFO_DEPTH));
    assign room      = ~full | pop;
    assign push_data = (state == ST_DATA) & scl_fall & got8 & room;

`ifdef I2C_RX_STRETCH_EN
    localparam logic [63:0] STRETCH_CYC64 =
        (64'(STRETCH_US) * 64'(CLK_FREQ)) / 64'd1_000_000;
    localparam logic [31:0] STRETCH_CYC = STRETCH_CYC64[31:0];

    logic [31:0] stretch_cnt;

    assign push = ~start_det & ~stop_det &
                  (push_data | ((state == ST_STRETCH) & pop));
`else
    assign push   = ~start_det & ~stop_det & push_data;
    assign scl_oe = 1'b0;
`endif

    i2c_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (I2C_BYTE_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({first_pend, shreg}),
        .pop   (pop),
        .rdata (head),
        .level (level)
    );

    assign m_valid = (level != '0);
    assign m_data  = m_valid ? head[I2C_BYTE_W-1:0] : '0;
    assign m_first = m_valid & head[I2C_BYTE_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd7;
            got8       <= 1'b0;
            shreg      <= '0;
            matched    <= 1'b0;
            first_pend <= 1'b0;
            sda_oe     <= 1'b0;
            bus_busy   <= 1'b0;
            stop_o     <= 1'b0;
            overflow   <= 1'b0;
`ifdef I2C_RX_STRETCH_EN
            scl_oe      <= 1'b0;
            stretch_cnt <= '0;
`endif
        end else begin
            stop_o   <= 1'b0;
            overflow <= 1'b0;
            if (start_det) begin
                state    <= ST_ADDR;
                bit_cnt  <= 3'd7;
                got8     <= 1'b0;
                matched  <= 1'b0;
                sda_oe   <= 1'b0;
                bus_busy <= 1'b1;
`ifdef I2C_RX_STRETCH_EN
                scl_oe   <= 1'b0;
`endif
            end else if (stop_det) begin
                state    <= ST_IDLE;
                stop_o   <= matched;
                matched  <= 1'b0;
                sda_oe   <= 1'b0;
                bus_busy <= 1'b0;
`ifdef I2C_RX_STRETCH_EN
                scl_oe   <= 1'b0;
`endif
            end else begin
                if (scl_rise && !got8 &&
                    (state == ST_ADDR || state == ST_DATA)) begin
                    shreg <= {shreg[I2C_BYTE_W-2:0], sda_s};
                    if (bit_cnt == 3'd0) begin
                        got8 <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                case (state)
                    ST_ADDR: begin
                        if (scl_fall && got8) begin
                            if (shreg[7:1] == own_addr && !shreg[0]) begin
                                state      <= ST_ADDR_ACK;
                                sda_oe     <= 1'b1;
                                matched    <= 1'b1;
                                first_pend <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_DATA_ACK: begin
`ifdef I2C_RX_STRETCH_EN
                        scl_oe <= 1'b0;
`endif
                        if (scl_fall) begin
                            state   <= ST_DATA;
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd7;
                            got8    <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (scl_fall && got8) begin
                            if (room) begin
                                state      <= ST_DATA_ACK;
                                sda_oe     <= 1'b1;
                                first_pend <= 1'b0;
`ifdef I2C_RX_STRETCH_EN
                            end else begin
                                state       <= ST_STRETCH;
                                scl_oe      <= 1'b1;
                                stretch_cnt <= '0;
                            end
`else
                            end else begin
                                state    <= ST_IGNORE;
                                overflow <= 1'b1;
                            end
`endif
                        end
                    end
`ifdef I2C_RX_STRETCH_EN
                    // SDA is driven one cycle before SCL is released so the
                    // ACK never looks like a START on the wire.
                    ST_STRETCH: begin
                        if (pop) begin
                            state      <= ST_DATA_ACK;
                            sda_oe     <= 1'b1;
                            first_pend <= 1'b0;
                        end else if (stretch_cnt + 1 >= STRETCH_CYC) begin
                            state    <= ST_IGNORE;
                            overflow <= 1'b1;
                            scl_oe   <= 1'b0;
                        end else begin
                            stretch_cnt <= stretch_cnt + 1'b1;
                        end
                    end
`endif
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: bit-banged master on an open-drain bus.
// Test 4 expectations follow I2C_RX_STRETCH_EN.
module tb_i2c_target_rx;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_oe;
    logic       sda_oe;
    logic [6:0] own_addr = 7'h42;
    logic [7:0] m_data;
    logic       m_first;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [2:0] level;
    logic       bus_busy;
    logic       stop_o;
    logic       overflow;
    logic       scl_line;
    logic       sda_line;

    int n_vec = 0;
    int n_bad = 0;
    int n_stop = 0;
    int n_ovf = 0;

    assign scl_line = scl_m & ~scl_oe;
    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_rx #(
        .CLK_FREQ    (50_000_000),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2),
        .STRETCH_US  (1000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_line),
        .sda_i    (sda_line),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .own_addr (own_addr),
        .m_data   (m_data),
        .m_first  (m_first),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .bus_busy (bus_busy),
        .stop_o   (stop_o),
        .overflow (overflow)
    );

    always @(posedge clk) begin
        if (stop_o) n_stop <= n_stop + 1;
        if (overflow) n_ovf <= n_ovf + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
    endtask

    task automatic scl_rel();
        int t;
        scl_m = 1'b1;
        t = 0;
        while (scl_line !== 1'b1 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) check("scl_release_timeout", 0, 1);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        wait_q();
        scl_rel();
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_q();
        scl_rel();
        wait_q();
        sda_m = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        wait_q();
        scl_rel();
        wait_q();
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1;
        wait_q();
        scl_rel();
        wait_q();
        ack = sda_line;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d,
                           input logic f);
        @(negedge clk);
        check({tag, "_valid"}, 32'(m_valid), 1);
        check({tag, "_data"}, 32'(m_data), 32'(d));
        check({tag, "_first"}, 32'(m_first), 32'(f));
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic stretch_helper();
        int t;
        t = 0;
        while (scl_oe !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("t4_scl_oe_seen", 32'(scl_oe), 1);
        repeat (100) @(negedge clk);
        check("t4_scl_still_held", 32'(scl_line), 0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        logic ack;
        int   s0;
        int   o0;
        logic [7:0] t4_bytes [5];
        t4_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_scl_oe", 32'(scl_oe), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_busy", 32'(bus_busy), 0);
        rst = 1'b0;
        wait_q();

        // Test 1: plain write of two bytes
        s0 = n_stop;
        bus_start();
        check("t1_busy", 32'(bus_busy), 1);
        send_byte(8'h84, ack);
        check("t1_addr_ack", 32'(ack), 0);
        send_byte(8'hA5, ack);
        check("t1_d0_ack", 32'(ack), 0);
        send_byte(8'h3C, ack);
        check("t1_d1_ack", 32'(ack), 0);
        bus_stop();
        check("t1_busy_off", 32'(bus_busy), 0);
        check("t1_level", 32'(level), 2);
        check("t1_stop", 32'(n_stop - s0), 1);
        pop_chk("t1_p0", 8'hA5, 1'b1);
        pop_chk("t1_p1", 8'h3C, 1'b0);

        // Test 2: address mismatch
        s0 = n_stop;
        bus_start();
        send_byte(8'h86, ack);
        check("t2_addr_nack", 32'(ack), 1);
        send_byte(8'h12, ack);
        check("t2_data_nack", 32'(ack), 1);
        bus_stop();
        check("t2_level", 32'(level), 0);
        check("t2_stop", 32'(n_stop - s0), 0);

        // Test 3: read request is not acknowledged
        bus_start();
        send_byte(8'h85, ack);
        check("t3_addr_nack", 32'(ack), 1);
        bus_stop();
        check("t3_level", 32'(level), 0);

        // Test 4: FIFO full on the fifth byte
        o0 = n_ovf;
        bus_start();
        send_byte(8'h84, ack);
        check("t4_addr_ack", 32'(ack), 0);
        for (int i = 0; i < 4; i++) begin
            send_byte(t4_bytes[i], ack);
            check("t4_ack", 32'(ack), 0);
        end
`ifdef I2C_RX_STRETCH_EN
        fork
            send_byte(8'h14, ack);
            stretch_helper();
        join
        check("t4_5th_ack", 32'(ack), 0);
        bus_stop();
        check("t4_ovf", 32'(n_ovf - o0), 0);
        check("t4_level", 32'(level), 4);
        for (int i = 1; i < 5; i++) pop_chk("t4_pop", t4_bytes[i], 1'b0);
`else
        send_byte(8'h14, ack);
        check("t4_5th_nack", 32'(ack), 1);
        bus_stop();
        check("t4_ovf", 32'(n_ovf - o0), 1);
        check("t4_level", 32'(level), 4);
        for (int i = 0; i < 4; i++) pop_chk("t4_pop", t4_bytes[i], i == 0);
`endif
        check("t4_empty", 32'(level), 0);

        // Test 5: repeated START discards a partial byte
        bus_start();
        send_byte(8'h84, ack);
        check("t5_addr0_ack", 32'(ack), 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_start();
        send_byte(8'h84, ack);
        check("t5_addr1_ack", 32'(ack), 0);
        send_byte(8'h5A, ack);
        check("t5_data_ack", 32'(ack), 0);
        bus_stop();
        check("t5_level", 32'(level), 1);
        pop_chk("t5_p0", 8'h5A, 1'b1);

        // Test 6: reset while the target is driving an ACK
        bus_start();
        send_byte(8'h84, ack);
        send_byte(8'h77, ack);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h99 >> i));
        sda_m = 1'b1;
        wait_q();
        scl_rel();
        @(negedge clk);
        check("t6_pre_sda_oe", 32'(sda_oe), 1);
        check("t6_pre_level", 32'(level), 2);
        rst = 1'b1;
        @(negedge clk);
        check("t6_sda_oe", 32'(sda_oe), 0);
        check("t6_valid", 32'(m_valid), 0);
        check("t6_level", 32'(level), 0);
        check("t6_busy", 32'(bus_busy), 0);
        rst = 1'b0;
        wait_q();
        scl_m = 1'b0;
        wait_q();
        bus_stop();
        bus_start();
        send_byte(8'h84, ack);
        check("t6_addr_ack", 32'(ack), 0);
        send_byte(8'h11, ack);
        check("t6_data_ack", 32'(ack), 0);
        bus_stop();
        pop_chk("t6_p0", 8'h11, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
